ps2_kbd_ascii: RTL and testbench
================================

// Module: ps2_kbd_ascii
// PURPOSE
//  PS/2 keyboard front end for the typing game. Deserialises PS/2 device frames and decodes set-2
//  make/break codes to ASCII. Queues key-press events in a FIFO and presents the head as
//  kbd_ascii/state, the pair the game logic consumes. The game pops one event per kbd_rd pulse.
// PARAMETERS
//  FIFO_DEPTH      8      ASCII event queue depth, power of 2, >=2
//  TIMEOUT_CYCLES  50000  idle clk cycles mid-frame before the bit counter is abandoned (1 ms @ 50 MHz)
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  reset      in   1  synchronous, active-high
//  ps2_clk    in   1  raw PS/2 clock, asynchronous
//  ps2_data   in   1  raw PS/2 data, asynchronous
//  kbd_rd     in   1  pop head event; ignored when FIFO empty
//  kbd_ascii  out  8  ASCII of FIFO head; 8'h00 when empty
//  state      out  2  00 idle, 01 event pending, 10 frame error latched (FIFO empty), 11 never driven
//  key_held   out  1  1 while the last-made key has not been released
//  overflow   out  1  sticky; set when an event is dropped on full FIFO; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; bit counter 0; break/ext/shift flags 0.
//  - Input sync: ps2_clk/ps2_data each through 3 flops. Falling edge = prev 1 & cur 0 on the synced clock.
//  - Frame: 11 bits sampled on falling edges: start 0, 8 data LSB-first, odd parity, stop 1.
//    - start==1: counter stays 0 and the edge is ignored.
//    - Parity or stop bad: frame discarded and error latched.
//    - Good frame: error cleared; byte strobed for one cycle, 1 cycle after the stop-bit edge.
//  - Watchdog: counter!=0 with no falling edge for TIMEOUT_CYCLES -> counter <= 0, no error flag.
//  - Decode (1 byte/cycle):
//    - E0 sets ext. F0 sets brk.
//    - Other byte with brk: release; brk,ext <= 0. If the code equals the held code, key_held <= 0.
//    - Other byte without brk: make; ext codes map to 00.
//    - Map covers letters 1C..1A -> 'a'..'z'; digits 45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9';
//      29 -> 20h, 5A -> 0Dh, 66 -> 08h; anything else -> 00h.
//    - Make with nonzero map: push; held code <= byte; key_held <= 1. Typematic repeats push again.
//    - Make with zero map: no push, key_held unchanged.
//  - FIFO: head visible combinationally on kbd_ascii.
//    - state=01 iff non-empty; else 10 if error latched; else 00.
//    - kbd_rd & non-empty: pop at the clk edge. Push & pop same cycle: both happen, count unchanged, also when full.
//    - Push on full without pop: event dropped, overflow <= 1.
//  - Latency: stop-bit falling edge (synced) -> state 01 in 3 clk when FIFO was empty.
//  - Reset mid-frame: partial frame lost; the next start bit is acquired normally.
// CONFIGURATION
//  - PS2_SHIFT_CAPS_EN defined:
//    - Track LSHIFT 12 / RSHIFT 59 make/break; Caps Lock 58 make toggles caps.
//    - Letters upper-case when shift XOR caps; digits with shift give !@#$%^&*() in set order.
//    - Shift/caps codes push nothing.
//  - PS2_SHIFT_CAPS_EN undefined: shift/caps ignored (map 00); output always lower-case.
// STRUCTURE
//  - Package ps2_kbd_pkg: PS2_BRK=8'hF0, PS2_EXT=8'hE0, PS2_LSHIFT, PS2_RSHIFT, PS2_CAPS;
//    state encodings KBD_IDLE/KBD_PEND/KBD_ERR; scancode-to-ASCII function.
//  - Sub-module ps2_frame_rx: synchroniser, edge detect, 11-bit shift, parity/stop check, watchdog.
//    Outputs byte + valid strobe + err strobe.
//  - Top: ps2_frame_rx + decoder flags + FIFO.
// TESTING
//  1. Frame 1C, then nothing -> within 3 clk of the stop edge: state=01, kbd_ascii=61h, key_held=1.
//     kbd_rd pulse -> state=00, kbd_ascii=00h.
//  2. Frames 1C, F0, 1C -> one event 61h queued; key_held 1 then 0 after the second 1C.
//     E0,75 -> no event.
//  3. Frame 32 with even parity -> no event, state=10. Then good frame 21 -> state=01, kbd_ascii=63h.
//  4. Send 10 makes of 1C with kbd_rd held 0, FIFO_DEPTH=8 -> 8 events queued, overflow=1.
//     Pops then yield 61h x8.
//  5. Frame with stop pulled after bit 5 (ps2_clk idle 50000 clk) -> watchdog clears.
//     The next full frame 4D decodes to 70h.
//  6. PS2_SHIFT_CAPS_EN: 12, 1C, F0, 12, 1C -> events 41h, 61h.
//     58, 1C -> 41h. Without the macro, the same sequences give only 61h events.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg
//   Shared definitions for the PS/2 keyboard front end.
//   - Scan-code set 2 control bytes (break prefix, extended prefix, shift/caps).
//   - Encodings of the 2-bit status presented to the game logic.
//   - ps2_scan_to_ascii(): maps a set-2 make code to ASCII. It returns 8'h00
//     for any code without a printable mapping.
//   Optional feature macro used by importers: PS2_SHIFT_CAPS_EN.
package ps2_kbd_pkg;

    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        KBD_IDLE = 2'b00,
        KBD_PEND = 2'b01,
        KBD_ERR  = 2'b10
    } kbd_state_e;

    // upper : letters become upper case
    // shift : digit keys produce their shifted symbol
    function automatic logic [7:0] ps2_scan_to_ascii(input logic [7:0] code,
                                                     input logic       upper,
                                                     input logic       shift);
        logic [7:0] result;
        result = 8'h00;
        case (code)
            8'h1C: result = 8'h61;  // a
            8'h32: result = 8'h62;  // b
            8'h21: result = 8'h63;  // c
            8'h23: result = 8'h64;  // d
            8'h24: result = 8'h65;  // e
            8'h2B: result = 8'h66;  // f
            8'h34: result = 8'h67;  // g
            8'h33: result = 8'h68;  // h
            8'h43: result = 8'h69;  // i
            8'h3B: result = 8'h6A;  // j
            8'h42: result = 8'h6B;  // k
            8'h4B: result = 8'h6C;  // l
            8'h3A: result = 8'h6D;  // m
            8'h31: result = 8'h6E;  // n
            8'h44: result = 8'h6F;  // o
            8'h4D: result = 8'h70;  // p
            8'h15: result = 8'h71;  // q
            8'h2D: result = 8'h72;  // r
            8'h1B: result = 8'h73;  // s
            8'h2C: result = 8'h74;  // t
            8'h3C: result = 8'h75;  // u
            8'h2A: result = 8'h76;  // v
            8'h1D: result = 8'h77;  // w
            8'h22: result = 8'h78;  // x
            8'h35: result = 8'h79;  // y
            8'h1A: result = 8'h7A;  // z
            8'h45: result = shift ? 8'h29 : 8'h30;  // 0 )
            8'h16: result = shift ? 8'h21 : 8'h31;  // 1 !
            8'h1E: result = shift ? 8'h40 : 8'h32;  // 2 @
            8'h26: result = shift ? 8'h23 : 8'h33;  // 3 #
            8'h25: result = shift ? 8'h24 : 8'h34;  // 4 $
            8'h2E: result = shift ? 8'h25 : 8'h35;  // 5 %
            8'h36: result = shift ? 8'h5E : 8'h36;  // 6 ^
            8'h3D: result = shift ? 8'h26 : 8'h37;  // 7 &
            8'h3E: result = shift ? 8'h2A : 8'h38;  // 8 *
            8'h46: result = shift ? 8'h28 : 8'h39;  // 9 (
            8'h29: result = 8'h20;  // space
            8'h5A: result = 8'h0D;  // enter
            8'h66: result = 8'h08;  // backspace
            default: result = 8'h00;
        endcase
        if (upper && (result >= 8'h61) && (result <= 8'h7A)) begin
            result = result - 8'h20;
        end
        return result;
    endfunction

endpackage

// File: rtl/ps2_kbd_ascii_frame_rx.sv
// ps2_frame_rx
//   Receives 11-bit PS/2 device-to-host frames (start, 8 data LSB-first,
//   odd parity, stop) and strobes out each byte.
//   Ports:
//     clk_i, reset_i   system clock, synchronous active-high reset
//     ps2_clk_i        raw PS/2 clock (asynchronous)
//     ps2_data_i       raw PS/2 data (asynchronous)
//     byte_o           last received byte, meaningful while valid_o is high
//     valid_o          one-cycle strobe, one clk after the stop-bit edge, good frame
//     err_o            one-cycle strobe for a frame with bad parity or stop bit
//     bit_cnt_o        debug view of the frame bit counter (0 = hunting for start)
//   A watchdog abandons a partial frame after TIMEOUT_CYCLES clk cycles
//   without a falling edge; that is not reported as an error.
import ps2_kbd_pkg::*;

module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o,
    output logic [3:0] bit_cnt_o
);

    localparam int             WDW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    logic [2:0]     clk_sync_q;
    logic [2:0]     data_sync_q;
    logic           clk_prev_q;
    logic [3:0]     bit_cnt_q;
    logic [8:0]     shift_q;     // 8 data bits + parity, shifted in from the top
    logic [7:0]     byte_q;
    logic           valid_q;
    logic           err_q;
    logic [WDW-1:0] idle_q;

    logic ps2_clk_s;
    logic ps2_data_s;
    logic fall;

    assign ps2_clk_s  = clk_sync_q[2];
    assign ps2_data_s = data_sync_q[2];
    assign fall       = clk_prev_q & ~ps2_clk_s;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // Synchronisers reset to the idle-high line level so that leaving
            // reset does not fabricate a falling edge.
            clk_sync_q  <= 3'b111;
            data_sync_q <= 3'b111;
            clk_prev_q  <= 1'b1;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 9'd0;
            byte_q      <= 8'd0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            idle_q      <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[1:0], ps2_data_i};
            clk_prev_q  <= ps2_clk_s;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;

            if (fall) begin
                idle_q <= '0;
                if (bit_cnt_q == 4'd0) begin
                    // A high start bit is line noise: keep hunting.
                    if (!ps2_data_s) begin
                        bit_cnt_q <= 4'd1;
                    end
                end else if (bit_cnt_q == 4'd10) begin
                    // Stop bit. Data + parity must have odd weight.
                    bit_cnt_q <= 4'd0;
                    byte_q    <= shift_q[7:0];
                    if ((^shift_q) && ps2_data_s) begin
                        valid_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end else begin
                    shift_q   <= {ps2_data_s, shift_q[8:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (bit_cnt_q != 4'd0) begin
                if (idle_q == WD_LAST) begin
                    bit_cnt_q <= 4'd0;
                    idle_q    <= '0;
                end else begin
                    idle_q <= idle_q + 1'b1;
                end
            end else begin
                idle_q <= '0;
            end
        end
    end

    assign byte_o    = byte_q;
    assign valid_o   = valid_q;
    assign err_o     = err_q;
    assign bit_cnt_o = bit_cnt_q;

endmodule

// File: rtl/ps2_kbd_ascii.sv
// ps2_kbd_ascii
//   PS/2 keyboard front end: frame receiver, set-2 make/break decoder and an
//   ASCII event FIFO whose head is presented to the game logic.
//   Ports:
//     clk, reset   system clock, synchronous active-high reset
//     ps2_clk      raw PS/2 clock
//     ps2_data     raw PS/2 data
//     kbd_rd       pop the FIFO head (ignored when empty)
//     kbd_ascii    ASCII of the FIFO head, 8'h00 when empty
//     state        00 idle, 01 event pending, 10 frame error latched
//     key_held     last-made key not yet released
//     overflow     sticky: an event was dropped on a full FIFO
//   Optional feature macro: PS2_SHIFT_CAPS_EN (shift/caps-lock aware mapping).
//
//   Handshake: kbd_ascii is valid whenever state == 01; kbd_rd high on a clk
//   edge while state == 01 consumes that head, and the next entry (or 8'h00)
//   appears after the same edge. kbd_rd while empty has no effect.
import ps2_kbd_pkg::*;

module ps2_kbd_ascii #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       kbd_rd,
    output logic [7:0] kbd_ascii,
    output logic [1:0] state,
    output logic       key_held,
    output logic       overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    // Frame receiver
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic [3:0] rx_bit_cnt;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk_i     (clk),
        .reset_i   (reset),
        .ps2_clk_i (ps2_clk),
        .ps2_data_i(ps2_data),
        .byte_o    (rx_byte),
        .valid_o   (rx_valid),
        .err_o     (rx_err),
        .bit_cnt_o (rx_bit_cnt)
    );

    // Decoder flags and FIFO state
    logic          brk_q;
    logic          ext_q;
    logic [7:0]    held_code_q;
    logic          key_held_q;
    logic          err_q;
    logic          overflow_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    mem_q [FIFO_DEPTH];

`ifdef PS2_SHIFT_CAPS_EN
    logic shift_l_q;
    logic shift_r_q;
    logic caps_q;
`endif

    logic       is_ext;
    logic       is_brk;
    logic       is_make;
    logic       is_release;
    logic       upper;
    logic       shifted;
    logic [7:0] map_ascii;
    logic       push_req;
    logic       empty;
    logic       full;
    logic       push;
    logic       pop;
    kbd_state_e state_cur;

    always_comb begin
        is_ext     = (rx_byte == PS2_EXT);
        is_brk     = (rx_byte == PS2_BRK);
        is_make    = rx_valid & ~is_ext & ~is_brk & ~brk_q;
        is_release = rx_valid & ~is_ext & ~is_brk & brk_q;
`ifdef PS2_SHIFT_CAPS_EN
        shifted = shift_l_q | shift_r_q;
        upper   = shifted ^ caps_q;
`else
        shifted = 1'b0;
        upper   = 1'b0;
`endif
        // Extended codes (arrows, keypad enter, ...) have no ASCII meaning here.
        map_ascii = ext_q ? 8'h00 : ps2_scan_to_ascii(rx_byte, upper, shifted);
        push_req  = is_make & (map_ascii != 8'h00);
    end

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(FIFO_DEPTH));
        pop   = kbd_rd & ~empty;
        // A simultaneous pop frees a slot, so a full FIFO still accepts.
        push  = push_req & (~full | pop);
        if (!empty) begin
            state_cur = KBD_PEND;
        end else if (err_q) begin
            state_cur = KBD_ERR;
        end else begin
            state_cur = KBD_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            held_code_q <= 8'h00;
            key_held_q  <= 1'b0;
            err_q       <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
`ifdef PS2_SHIFT_CAPS_EN
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            caps_q      <= 1'b0;
`endif
        end else begin
            if (rx_err) begin
                err_q <= 1'b1;
            end
            if (rx_valid) begin
                err_q <= 1'b0;
                if (is_ext) begin
                    ext_q <= 1'b1;
                end else if (is_brk) begin
                    brk_q <= 1'b1;
                end else if (brk_q) begin
                    brk_q <= 1'b0;
                    ext_q <= 1'b0;
                    if (rx_byte == held_code_q) begin
                        key_held_q <= 1'b0;
                    end
                end else begin
                    // Make: the prefix only qualifies this one code.
                    ext_q <= 1'b0;
                    if (map_ascii != 8'h00) begin
                        held_code_q <= rx_byte;
                        key_held_q  <= 1'b1;
                    end
                end
            end

`ifdef PS2_SHIFT_CAPS_EN
            if (is_make && !ext_q) begin
                if (rx_byte == PS2_LSHIFT) shift_l_q <= 1'b1;
                if (rx_byte == PS2_RSHIFT) shift_r_q <= 1'b1;
                if (rx_byte == PS2_CAPS)   caps_q    <= ~caps_q;
            end
            if (is_release && !ext_q) begin
                if (rx_byte == PS2_LSHIFT) shift_l_q <= 1'b0;
                if (rx_byte == PS2_RSHIFT) shift_r_q <= 1'b0;
            end
`endif

            if (push_req && !push) begin
                overflow_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= map_ascii;
        end
    end

    assign kbd_ascii = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign state     = state_cur;
    assign key_held  = key_held_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
`timescale 1ns/1ps
module tb_ps2_kbd_ascii;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic kbd_rd = 1'b0;
  logic [7:0] kbd_ascii;
  logic [1:0] state;
  logic key_held;
  logic overflow;

  always #5 clk = ~clk;

  ps2_kbd_ascii #(
    .FIFO_DEPTH(8),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .kbd_rd(kbd_rd),
    .kbd_ascii(kbd_ascii),
    .state(state),
    .key_held(key_held),
    .overflow(overflow)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int pend_cyc = 0;
  logic [1:0] prev_state = 2'b00;
  logic auto_pop = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  // record the cycle at which an event becomes pending
  always @(negedge clk) begin
    if (state == 2'b01 && prev_state != 2'b01) pend_cyc = cyc;
    prev_state = state;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: pops and compares each presented event
  always @(negedge clk) begin
    if (kbd_rd) begin
      kbd_rd = 1'b0;
    end else if (auto_pop && state == 2'b01) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got %h expected none", kbd_ascii);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (kbd_ascii !== e) begin
          failures++;
          $display("FAIL event: got %h expected %h", kbd_ascii, e);
        end
      end
      kbd_rd = 1'b1;
    end
  end

  // driver: PS/2 device frame, data changes while ps2_clk is high
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    logic par;
    par = bad_par ? (^b) : ~(^b);
    fr = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = fr[i];
      repeat (8) @(negedge clk);
      if (i == 10) stop_cyc = cyc;
      ps2_clk = 1'b0;
      repeat (8) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || state == 2'b01 || kbd_rd) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL drain_timeout: got %0d queued expected 0", exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", {6'd0, state}, 8'h00);
    check("reset_ascii", kbd_ascii, 8'h00);
    check("reset_held", {7'd0, key_held}, 8'h00);
    check("reset_ovf", {7'd0, overflow}, 8'h00);

    // 1: single make, latency, then pop
    key(8'h1C);
    lat = pend_cyc - stop_cyc;
    checks++;
    if (lat < 1 || lat > 6) begin
      failures++;
      $display("FAIL latency: got %0d expected 1..6", lat);
    end
    check("t1_state", {6'd0, state}, 8'h01);
    check("t1_ascii", kbd_ascii, 8'h61);
    check("t1_held", {7'd0, key_held}, 8'h01);
    exp_q.push_back(8'h61);
    auto_pop = 1'b1;
    wait_drain();
    @(negedge clk);
    check("t1_state_after_pop", {6'd0, state}, 8'h00);
    check("t1_ascii_after_pop", kbd_ascii, 8'h00);

    // 2: make/break, extended codes
    key(8'hF0); key(8'h1C);
    check("t2_released", {7'd0, key_held}, 8'h00);
    exp_q.push_back(8'h61);
    key(8'h1C);
    check("t2_held", {7'd0, key_held}, 8'h01);
    key(8'hF0); key(8'h1C);
    check("t2_held_clear", {7'd0, key_held}, 8'h00);
    key(8'hE0); key(8'h75);
    key(8'hE0); key(8'h5A);
    exp_q.push_back(8'h61);
    key(8'h1C);
    key(8'hF0); key(8'h1C);
    wait_drain();

    // 3: parity error, then good frame clears it
    auto_pop = 1'b0;
    send_frame(8'h32, 1'b1, 11);
    check("t3_err_state", {6'd0, state}, 8'h02);
    key(8'h21);
    check("t3_state", {6'd0, state}, 8'h01);
    check("t3_ascii", kbd_ascii, 8'h63);
    exp_q.push_back(8'h63);
    auto_pop = 1'b1;
    wait_drain();
    key(8'hF0); key(8'h21);

    // 4: overflow with reads held off
    auto_pop = 1'b0;
    for (int i = 0; i < 10; i++) key(8'h1C);
    check("t4_ovf", {7'd0, overflow}, 8'h01);
    check("t4_state", {6'd0, state}, 8'h01);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h61);
    auto_pop = 1'b1;
    wait_drain();
    check("t4_empty", {6'd0, state}, 8'h00);
    key(8'hF0); key(8'h1C);

    // 5: truncated frame abandoned by the watchdog
    send_frame(8'h4D, 1'b0, 5);
    repeat (1200) @(negedge clk);
    check("t5_no_err", {6'd0, state}, 8'h00);
    exp_q.push_back(8'h70);
    key(8'h4D);
    key(8'hF0); key(8'h4D);
    wait_drain();

    // 6: shift / caps lock
`ifdef PS2_SHIFT_CAPS_EN
    key(8'h12); exp_q.push_back(8'h41); key(8'h1C);
    key(8'hF0); key(8'h12); exp_q.push_back(8'h61); key(8'h1C);
    key(8'h58); exp_q.push_back(8'h41); key(8'h1C);
`else
    key(8'h12); exp_q.push_back(8'h61); key(8'h1C);
    key(8'hF0); key(8'h12); exp_q.push_back(8'h61); key(8'h1C);
    key(8'h58); exp_q.push_back(8'h61); key(8'h1C);
`endif
    wait_drain();

    // reset mid-frame: partial frame lost, sticky overflow cleared
    send_frame(8'h1C, 1'b0, 4);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ovf", {7'd0, overflow}, 8'h00);
    check("rst_held", {7'd0, key_held}, 8'h00);
    exp_q.push_back(8'h61);
    key(8'h1C);
    wait_drain();
    check("final_state", {6'd0, state}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
